// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite master adaptor: response codes,
// FSM state encodings and a response classification helper.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_ADDR = 2'b01,
        W_RESP = 2'b10
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_ADDR = 2'b01,
        R_DATA = 2'b10
    } rd_state_e;

    // Any response other than OKAY counts as an error completion.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != RESP_OKAY);
    endfunction

endpackage

// File: rtl/axi4_lite_sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones.
module axi4_lite_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: step by one unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/axi4_lite_master_adaptor.sv
// AXI4-Lite master: turns local write/read commands into AXI4-Lite
// transactions with independent write and read FSMs (one outstanding each).
// Optional error counters are built when AXI4_LITE_MASTER_ERR_CNT_EN is defined.
module axi4_lite_master_adaptor
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
    ,
    parameter int ERR_CNT_W  = 8
`endif
) (
    input  logic                    aclk,
    input  logic                    areset,
    // local write command / completion
    input  logic                    wr_start_in,
    input  logic [ADDR_WIDTH-1:0]   wr_addr_in,
    input  logic [DATA_WIDTH-1:0]   wr_data_in,
    input  logic [DATA_WIDTH/8-1:0] wr_strb_in,
    input  logic [2:0]              wr_prot_in,
    output logic                    wr_ready_out,
    output logic                    wr_done_out,
    output logic [1:0]              wr_resp_out,
    // local read command / completion
    input  logic                    rd_start_in,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_in,
    input  logic [2:0]              rd_prot_in,
    output logic                    rd_ready_out,
    output logic                    rd_done_out,
    output logic [DATA_WIDTH-1:0]   rd_data_out,
    output logic [1:0]              rd_resp_out,
    // AW channel
    output logic [ADDR_WIDTH-1:0]   awaddr_out,
    output logic [2:0]              awprot_out,
    output logic                    awvalid_out,
    input  logic                    awready_in,
    // W channel
    output logic [DATA_WIDTH-1:0]   wdata_out,
    output logic [DATA_WIDTH/8-1:0] wstrb_out,
    output logic                    wvalid_out,
    input  logic                    wready_in,
    // B channel
    input  logic [1:0]              bresp_in,
    input  logic                    bvalid_in,
    output logic                    bready_out,
    // AR channel
    output logic [ADDR_WIDTH-1:0]   araddr_out,
    output logic [2:0]              arprot_out,
    output logic                    arvalid_out,
    input  logic                    arready_in,
    // R channel
    input  logic [DATA_WIDTH-1:0]   rdata_in,
    input  logic [1:0]              rresp_in,
    input  logic                    rvalid_in,
    output logic                    rready_out
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]    wr_err_cnt_out,
    output logic [ERR_CNT_W-1:0]    rd_err_cnt_out
`endif
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // ---------------- write path ----------------
    wr_state_e               wr_state_q, wr_state_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q,   awaddr_d;
    logic [2:0]              awprot_q,   awprot_d;
    logic [DATA_WIDTH-1:0]   wdata_q,    wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q,    wstrb_d;
    logic                    awvalid_q,  awvalid_d;
    logic                    wvalid_q,   wvalid_d;
    logic                    bready_q,   bready_d;
    logic                    wr_ready_q, wr_ready_d;
    logic                    wr_done_q,  wr_done_d;
    logic [1:0]              wr_resp_q,  wr_resp_d;
    logic                    aw_pend_s;
    logic                    w_pend_s;

    // A channel stays pending while its valid is up and not yet accepted.
    assign aw_pend_s = awvalid_q & ~awready_in;
    assign w_pend_s  = wvalid_q  & ~wready_in;

    // Write FSM next state and next register values.
    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        awprot_d   = awprot_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        wr_done_d  = 1'b0;
        wr_resp_d  = wr_resp_q;
        case (wr_state_q)
            W_IDLE: begin
                if (wr_ready_q && wr_start_in) begin
                    awaddr_d   = wr_addr_in;
                    awprot_d   = wr_prot_in;
                    wdata_d    = wr_data_in;
                    wstrb_d    = wr_strb_in;
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                    wr_state_d = W_ADDR;
                end else begin
                    wr_state_d = W_IDLE;
                end
            end
            W_ADDR: begin
                // AW and W retire independently; B is opened once both are gone.
                awvalid_d = aw_pend_s;
                wvalid_d  = w_pend_s;
                if (!aw_pend_s && !w_pend_s) begin
                    bready_d   = 1'b1;
                    wr_state_d = W_RESP;
                end else begin
                    wr_state_d = W_ADDR;
                end
            end
            W_RESP: begin
                if (bvalid_in && bready_q) begin
                    wr_resp_d  = bresp_in;
                    wr_done_d  = 1'b1;
                    bready_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end else begin
                    wr_state_d = W_RESP;
                end
            end
            default: begin
                awvalid_d  = 1'b0;
                wvalid_d   = 1'b0;
                bready_d   = 1'b0;
                wr_state_d = W_IDLE;
            end
        endcase
        // Ready reopens the cycle after the done pulse.
        wr_ready_d = (wr_state_d == W_IDLE) && !wr_done_d;
    end

    // Write path registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state_q <= W_IDLE;
            awaddr_q   <= {ADDR_WIDTH{1'b0}};
            awprot_q   <= 3'b000;
            wdata_q    <= {DATA_WIDTH{1'b0}};
            wstrb_q    <= {STRB_WIDTH{1'b0}};
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            wr_ready_q <= 1'b1;
            wr_done_q  <= 1'b0;
            wr_resp_q  <= 2'b00;
        end else begin
            wr_state_q <= wr_state_d;
            awaddr_q   <= awaddr_d;
            awprot_q   <= awprot_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            wr_ready_q <= wr_ready_d;
            wr_done_q  <= wr_done_d;
            wr_resp_q  <= wr_resp_d;
        end
    end

    // ---------------- read path ----------------
    rd_state_e               rd_state_q, rd_state_d;
    logic [ADDR_WIDTH-1:0]   araddr_q,   araddr_d;
    logic [2:0]              arprot_q,   arprot_d;
    logic                    arvalid_q,  arvalid_d;
    logic                    rready_q,   rready_d;
    logic                    rd_ready_q, rd_ready_d;
    logic                    rd_done_q,  rd_done_d;
    logic [DATA_WIDTH-1:0]   rd_data_q,  rd_data_d;
    logic [1:0]              rd_resp_q,  rd_resp_d;

    // Read FSM next state and next register values.
    always_comb begin
        rd_state_d = rd_state_q;
        araddr_d   = araddr_q;
        arprot_d   = arprot_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        rd_done_d  = 1'b0;
        rd_data_d  = rd_data_q;
        rd_resp_d  = rd_resp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (rd_ready_q && rd_start_in) begin
                    araddr_d   = rd_addr_in;
                    arprot_d   = rd_prot_in;
                    arvalid_d  = 1'b1;
                    rd_state_d = R_ADDR;
                end else begin
                    rd_state_d = R_IDLE;
                end
            end
            R_ADDR: begin
                if (arvalid_q && arready_in) begin
                    arvalid_d  = 1'b0;
                    rready_d   = 1'b1;
                    rd_state_d = R_DATA;
                end else begin
                    rd_state_d = R_ADDR;
                end
            end
            R_DATA: begin
                if (rvalid_in && rready_q) begin
                    rd_data_d  = rdata_in;
                    rd_resp_d  = rresp_in;
                    rd_done_d  = 1'b1;
                    rready_d   = 1'b0;
                    rd_state_d = R_IDLE;
                end else begin
                    rd_state_d = R_DATA;
                end
            end
            default: begin
                arvalid_d  = 1'b0;
                rready_d   = 1'b0;
                rd_state_d = R_IDLE;
            end
        endcase
        rd_ready_d = (rd_state_d == R_IDLE) && !rd_done_d;
    end

    // Read path registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_state_q <= R_IDLE;
            araddr_q   <= {ADDR_WIDTH{1'b0}};
            arprot_q   <= 3'b000;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            rd_ready_q <= 1'b1;
            rd_done_q  <= 1'b0;
            rd_data_q  <= {DATA_WIDTH{1'b0}};
            rd_resp_q  <= 2'b00;
        end else begin
            rd_state_q <= rd_state_d;
            araddr_q   <= araddr_d;
            arprot_q   <= arprot_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            rd_ready_q <= rd_ready_d;
            rd_done_q  <= rd_done_d;
            rd_data_q  <= rd_data_d;
            rd_resp_q  <= rd_resp_d;
        end
    end

    // ---------------- optional error counters ----------------
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
    logic wr_err_inc_s;
    logic rd_err_inc_s;

    assign wr_err_inc_s = (wr_state_q == W_RESP) && bvalid_in && bready_q && resp_is_err(bresp_in);
    assign rd_err_inc_s = (rd_state_q == R_DATA) && rvalid_in && rready_q && resp_is_err(rresp_in);

    axi4_lite_sat_counter #(.WIDTH(ERR_CNT_W)) u_wr_err_cnt (
        .clk_i   (aclk),
        .rst_i   (areset),
        .inc_i   (wr_err_inc_s),
        .count_o (wr_err_cnt_out)
    );

    axi4_lite_sat_counter #(.WIDTH(ERR_CNT_W)) u_rd_err_cnt (
        .clk_i   (aclk),
        .rst_i   (areset),
        .inc_i   (rd_err_inc_s),
        .count_o (rd_err_cnt_out)
    );
`else
`endif

    // ---------------- outputs ----------------
    assign wr_ready_out = wr_ready_q;
    assign wr_done_out  = wr_done_q;
    assign wr_resp_out  = wr_resp_q;
    assign awaddr_out   = awaddr_q;
    assign awprot_out   = awprot_q;
    assign awvalid_out  = awvalid_q;
    assign wdata_out    = wdata_q;
    assign wstrb_out    = wstrb_q;
    assign wvalid_out   = wvalid_q;
    assign bready_out   = bready_q;

    assign rd_ready_out = rd_ready_q;
    assign rd_done_out  = rd_done_q;
    assign rd_data_out  = rd_data_q;
    assign rd_resp_out  = rd_resp_q;
    assign araddr_out   = araddr_q;
    assign arprot_out   = arprot_q;
    assign arvalid_out  = arvalid_q;
    assign rready_out   = rready_q;

endmodule
